// File: rtl/score_tracker.sv
// N-player saturating score keeper with per-player active-low HEX digits and game-winner latch.
// Optional build macro SCORE_AUTO_RESTART_EN: leave GAME_OVER automatically after RESTART_CYCLES cycles.
module score_tracker #(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_SCORE      = 7,
  parameter int SCORE_W        = 4,
  parameter int RESTART_CYCLES = 8,
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     hardReset,
  input  logic [NUM_PLAYERS-1:0]   point,
  output logic                     reset,
  output logic                     gameOver,
  output logic [WIN_W-1:0]         winner,
  output logic [7*NUM_PLAYERS-1:0] display
);

  typedef enum logic {PLAY, GAME_OVER} state_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  state_t             state;
  logic [SCORE_W-1:0] score [NUM_PLAYERS];
  logic [WIN_W-1:0]   winIdx;
  logic               anyPoint;
  logic [SCORE_W-1:0] winScore;
  logic [SCORE_W-1:0] nextScore;
  logic               hitMax;
  logic               canScore;
  logic               restartNow;

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 6 || MAX_SCORE < 1 || MAX_SCORE > 9 ||
      (1 << SCORE_W) <= MAX_SCORE || RESTART_CYCLES < 1) begin : g_badParams
    $error("score_tracker: parameter out of range");
  end

  function automatic logic [6:0] segEncode(input logic [SCORE_W-1:0] v);
    logic [6:0] seg;
    case (32'(v))
      0:       seg = 7'b1000000;
      1:       seg = 7'b1111001;
      2:       seg = 7'b0100100;
      3:       seg = 7'b0110000;
      4:       seg = 7'b0011001;
      5:       seg = 7'b0010010;
      6:       seg = 7'b0000010;
      7:       seg = 7'b1111000;
      8:       seg = 7'b0000000;
      9:       seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Lowest-index asserted point wins the round; higher bits in the same cycle are dropped.
  always_comb begin
    winIdx   = '0;
    anyPoint = |point;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (point[i]) winIdx = WIN_W'(i);
    end
    winScore  = score[winIdx];
    nextScore = winScore + 1'b1;
    canScore  = (state == PLAY) && anyPoint && (winScore < SCORE_W'(MAX_SCORE));
    hitMax    = (nextScore == SCORE_W'(MAX_SCORE));
  end

`ifdef SCORE_AUTO_RESTART_EN
  localparam int CNT_W = $clog2(RESTART_CYCLES + 1);
  logic [CNT_W-1:0] holdCnt;
  assign restartNow = (state == GAME_OVER) && (holdCnt == CNT_W'(RESTART_CYCLES - 1));
`else
  assign restartNow = 1'b0;
`endif

  assign reset = hardReset | ((state == PLAY) & anyPoint) | restartNow;

  always_ff @(posedge clk) begin
    if (hardReset) begin
      state    <= PLAY;
      gameOver <= 1'b0;
      winner   <= '0;
      display  <= {NUM_PLAYERS{SEG_ZERO}};
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
`ifdef SCORE_AUTO_RESTART_EN
      holdCnt  <= '0;
`endif
    end else begin
      // Digits track the score registers one cycle behind.
      for (int i = 0; i < NUM_PLAYERS; i++) display[7*i +: 7] <= segEncode(score[i]);
      if (state == PLAY) begin
        if (canScore) begin
          score[winIdx] <= nextScore;
          if (hitMax) begin
            state    <= GAME_OVER;
            gameOver <= 1'b1;
            winner   <= winIdx;
`ifdef SCORE_AUTO_RESTART_EN
            holdCnt  <= '0;
`endif
          end
        end
      end else begin
`ifdef SCORE_AUTO_RESTART_EN
        if (restartNow) begin
          state    <= PLAY;
          gameOver <= 1'b0;
          winner   <= '0;
          holdCnt  <= '0;
          for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
        end else begin
          holdCnt <= holdCnt + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker (2 players, MAX_SCORE=3, RESTART_CYCLES=4).
module tb_score_tracker;

  localparam int NP  = 2;
  localparam int MAX = 3;
  localparam int RC  = 4;
`ifdef SCORE_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic [13:0] disp;
    logic        go;
    logic        win;
  } exp_t;

  logic        clk;
  logic        hardReset;
  logic [1:0]  point;
  logic        reset;
  logic        gameOver;
  logic        winner;
  logic [13:0] display;

  int checks = 0;
  int errors = 0;

  logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  exp_t expQ [$];
  int   mScore [NP];
  bit   mGo;
  bit   mWin;
  int   mHold;

  score_tracker #(
    .NUM_PLAYERS(NP),
    .MAX_SCORE(MAX),
    .SCORE_W(4),
    .RESTART_CYCLES(RC)
  ) dut (
    .clk(clk),
    .hardReset(hardReset),
    .point(point),
    .reset(reset),
    .gameOver(gameOver),
    .winner(winner),
    .display(display)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, check the combinational reset, predict the post-edge outputs.
  task automatic applyStimulus(input logic hr, input logic [1:0] pt);
    logic expReset;
    logic restart;
    int   idx;
    exp_t e;
    exp_t got;
    @(negedge clk);
    hardReset = hr;
    point     = pt;
    #1;
    restart  = AUTO && mGo && (mHold == RC - 1);
    expReset = hr || (!mGo && pt != 2'b00) || restart;
    checkOutput("reset", 32'(reset), 32'(expReset));
    e.disp = hr ? {2{segTab[0]}} : {segTab[mScore[1]], segTab[mScore[0]]};
    if (hr) begin
      mScore = '{0, 0};
      mGo = 1'b0; mWin = 1'b0; mHold = 0;
    end else if (!mGo && pt != 2'b00) begin
      idx = pt[0] ? 0 : 1;
      if (mScore[idx] < MAX) mScore[idx]++;
      if (mScore[idx] == MAX) begin
        mGo = 1'b1; mWin = (idx == 1); mHold = 0;
      end
    end else if (mGo) begin
      if (restart) begin
        mScore = '{0, 0};
        mGo = 1'b0; mWin = 1'b0; mHold = 0;
      end else begin
        mHold++;
      end
    end
    e.go  = mGo;
    e.win = mWin;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput("display", 32'(display), 32'(got.disp));
    checkOutput("gameOver", 32'(gameOver), 32'(got.go));
    checkOutput("winner", 32'(winner), 32'(got.win));
  endtask

  initial begin
    hardReset = 1'b0;
    point     = 2'b00;
    mScore    = '{0, 0};
    mGo = 1'b0; mWin = 1'b0; mHold = 0;

    applyStimulus(1'b1, 2'b00);
    checkOutput("resetDisplay", 32'(display), 32'(14'b1000000_1000000));
    applyStimulus(1'b0, 2'b00);

    applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b0, 2'b00);
    checkOutput("p0OneDigit", 32'(display), 32'(14'b1000000_1111001));

    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b00);
    checkOutput("bothPointsP0Only", 32'(display), 32'(14'b1000000_0100100));

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b10);
      applyStimulus(1'b0, 2'b00);
    end
    checkOutput("p1Wins", 32'({gameOver, winner}), 32'(2'b11));

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 2'b00);

    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b0, 2'b00);
    checkOutput("resetBeatsPoint", 32'(display), 32'(14'b1000000_1000000));

    applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b0, 2'b00);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b10);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b1, 2'b11);

    for (int i = 0; i < 120; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
